// File: rtl/connect4_engine.sv
// Connect-4 move engine: stacks dropped pieces and, over four CHECK cycles, counts the
// run through the last piece along each line direction to detect wins and draws.
module connect4_engine #(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int WIN_LEN = 4,
    localparam int N  = ROWS * COLS,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int MW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          drop_valid,
    input  logic [CW-1:0] drop_col,
    input  logic          new_game,
    output logic          drop_ready,
    output logic [N-1:0]  occupied,
    output logic [N-1:0]  owner,
    output logic          current_player,
    output logic [1:0]    game_status,
    output logic [MW-1:0] move_count,
    output logic          illegal_move
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] OVER  = 2'd2;

    logic [1:0]    state;
    logic [1:0]    d;
    logic          win_flag;
    logic [RW-1:0] last_row;
    logic [CW-1:0] last_col;

    logic [N-1:0]  land_mask;
    logic [RW-1:0] land_row;
    logic          col_open;
    logic          dir_win;

    assign drop_ready = (state == IDLE);

    // Lowest empty cell of the requested column; col_open stays 0 when the column is
    // full or out of range, which is exactly the reject condition.
    always_comb begin
        land_mask = '0;
        land_row  = '0;
        col_open  = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            if (int'(drop_col) == c) begin
                for (int r = 0; r < ROWS; r++) begin
                    if (!col_open && !occupied[r*COLS+c]) begin
                        land_mask[r*COLS+c] = 1'b1;
                        land_row            = RW'(r);
                        col_open            = 1'b1;
                    end
                end
            end
        end
    end

    // Run length through (last_row, last_col) along direction d, walking both ways.
    always_comb begin
        int  dr, dc, run, rr, cc;
        logic stop;
        dr   = 0;
        dc   = 1;
        run  = 1;
        rr   = 0;
        cc   = 0;
        stop = 1'b0;
        case (d)
            2'd0:    begin dr = 0; dc = 1;  end
            2'd1:    begin dr = 1; dc = 0;  end
            2'd2:    begin dr = 1; dc = 1;  end
            default: begin dr = 1; dc = -1; end
        endcase
        for (int s = -1; s <= 1; s += 2) begin
            stop = 1'b0;
            for (int k = 1; k < WIN_LEN; k++) begin
                rr = int'(last_row) + s * k * dr;
                cc = int'(last_col) + s * k * dc;
                if (!stop) begin
                    if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS)
                        stop = 1'b1;
                    else if (occupied[rr*COLS+cc] && owner[rr*COLS+cc] == current_player)
                        run = run + 1;
                    else
                        stop = 1'b1;
                end
            end
        end
        dir_win = (run >= WIN_LEN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            d              <= '0;
            occupied       <= '0;
            owner          <= '0;
            current_player <= 1'b0;
            game_status    <= 2'b00;
            move_count     <= '0;
            illegal_move   <= 1'b0;
            win_flag       <= 1'b0;
            last_row       <= '0;
            last_col       <= '0;
        end else begin
            illegal_move <= 1'b0;
            if (new_game) begin
                state          <= IDLE;
                d              <= '0;
                occupied       <= '0;
                owner          <= '0;
                current_player <= 1'b0;
                game_status    <= 2'b00;
                move_count     <= '0;
                win_flag       <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (drop_valid) begin
                        if (col_open) begin
                            occupied   <= occupied | land_mask;
                            owner      <= owner | (land_mask & {N{current_player}});
                            last_row   <= land_row;
                            last_col   <= drop_col;
                            move_count <= move_count + 1'b1;
                            win_flag   <= 1'b0;
                            d          <= '0;
                            state      <= CHECK;
                        end else begin
                            illegal_move <= 1'b1;
                        end
                    end
                    CHECK: begin
                        d <= d + 2'd1;
                        if (dir_win) win_flag <= 1'b1;
                        // Last direction: a win outranks a draw even on the final cell.
                        if (d == 2'd3) begin
                            if (win_flag || dir_win) begin
                                game_status <= current_player ? 2'b10 : 2'b01;
                                state       <= OVER;
                            end else if (move_count == MW'(N)) begin
                                game_status <= 2'b11;
                                state       <= OVER;
                            end else begin
                                current_player <= ~current_player;
                                state          <= IDLE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_connect4_engine.sv
// Bench for connect4_engine: three parameterizations driven against a board-level
// reference model that detects wins by scanning every window on the board.
module tb_connect4_engine;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic v0, ng0, rdy0, cp0, ill0; logic [1:0] c0, st0; logic [15:0] occ0, own0; logic [4:0] mc0;
    logic v1, ng1, rdy1, cp1, ill1; logic [2:0] c1; logic [1:0] st1; logic [19:0] occ1, own1; logic [4:0] mc1;
    logic v2, ng2, rdy2, cp2, ill2; logic [0:0] c2; logic [1:0] st2; logic [3:0] occ2, own2; logic [2:0] mc2;

    connect4_engine #(.ROWS(4), .COLS(4), .WIN_LEN(4)) u_d0 (
        .clk(clk), .reset(reset), .drop_valid(v0), .drop_col(c0), .new_game(ng0),
        .drop_ready(rdy0), .occupied(occ0), .owner(own0), .current_player(cp0),
        .game_status(st0), .move_count(mc0), .illegal_move(ill0));
    connect4_engine #(.ROWS(4), .COLS(5), .WIN_LEN(4)) u_d1 (
        .clk(clk), .reset(reset), .drop_valid(v1), .drop_col(c1), .new_game(ng1),
        .drop_ready(rdy1), .occupied(occ1), .owner(own1), .current_player(cp1),
        .game_status(st1), .move_count(mc1), .illegal_move(ill1));
    connect4_engine #(.ROWS(2), .COLS(2), .WIN_LEN(4)) u_d2 (
        .clk(clk), .reset(reset), .drop_valid(v2), .drop_col(c2), .new_game(ng2),
        .drop_ready(rdy2), .occupied(occ2), .owner(own2), .current_player(cp2),
        .game_status(st2), .move_count(mc2), .illegal_move(ill2));

    int pass_cnt = 0;
    int tot_cnt  = 0;

    // ---------------- reference model ----------------
    int brd[8][8];
    int m_rows, m_cols, m_win, m_player, m_count;
    logic [1:0] m_status;

    function automatic void m_init(input int r, input int c, input int w);
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) brd[i][j] = -1;
        m_rows = r; m_cols = c; m_win = w; m_player = 0; m_count = 0; m_status = 2'b00;
    endfunction

    function automatic bit m_line(input int p);
        for (int r = 0; r < m_rows; r++)
            for (int c = 0; c < m_cols; c++)
                for (int dir = 0; dir < 4; dir++) begin
                    int dr, dc; bit ok;
                    dr = (dir == 0) ? 0 : 1;
                    dc = (dir == 1) ? 0 : ((dir == 3) ? -1 : 1);
                    ok = 1'b1;
                    for (int k = 0; k < m_win; k++) begin
                        int rr, cc;
                        rr = r + k * dr; cc = c + k * dc;
                        if (rr < 0 || rr >= m_rows || cc < 0 || cc >= m_cols) ok = 1'b0;
                        else if (brd[rr][cc] != p) ok = 1'b0;
                    end
                    if (ok) return 1'b1;
                end
        return 1'b0;
    endfunction

    // 1 = accepted, 0 = rejected, 2 = ignored because the game is over
    function automatic int m_drop(input int col);
        if (m_status != 2'b00) return 2;
        if (col >= m_cols) return 0;
        for (int r = 0; r < m_rows; r++)
            if (brd[r][col] < 0) begin
                brd[r][col] = m_player;
                m_count++;
                if (m_line(m_player)) m_status = (m_player == 1) ? 2'b10 : 2'b01;
                else if (m_count == m_rows * m_cols) m_status = 2'b11;
                else m_player = 1 - m_player;
                return 1;
            end
        return 0;
    endfunction

    function automatic logic [63:0] m_occ();
        logic [63:0] v = '0;
        for (int r = 0; r < m_rows; r++) for (int c = 0; c < m_cols; c++)
            if (brd[r][c] >= 0) v[r*m_cols+c] = 1'b1;
        return v;
    endfunction

    function automatic logic [63:0] m_own();
        logic [63:0] v = '0;
        for (int r = 0; r < m_rows; r++) for (int c = 0; c < m_cols; c++)
            if (brd[r][c] == 1) v[r*m_cols+c] = 1'b1;
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic play0(input int col, output int r);
        r = m_drop(col);
        @(negedge clk); v0 = 1'b1; c0 = 2'(col);
        @(negedge clk); v0 = 1'b0;
        if (r == 1) repeat (4) @(negedge clk);
    endtask

    task automatic play1(input int col, output int r);
        r = m_drop(col);
        @(negedge clk); v1 = 1'b1; c1 = 3'(col);
        @(negedge clk); v1 = 1'b0;
        if (r == 1) repeat (4) @(negedge clk);
    endtask

    task automatic play2(input int col, output int r);
        r = m_drop(col);
        @(negedge clk); v2 = 1'b1; c2 = 1'(col);
        @(negedge clk); v2 = 1'b0;
        if (r == 1) repeat (4) @(negedge clk);
    endtask

    task automatic newgame0();
        @(negedge clk); ng0 = 1'b1; @(negedge clk); ng0 = 1'b0; m_init(4, 4, 4);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [63:0] eo, ew;
        reset = 1'b0; v0 = 0; v1 = 0; v2 = 0; ng0 = 0; ng1 = 0; ng2 = 0; c0 = 0; c1 = 0; c2 = 0;
        #2;
        tot_cnt++;
        if ({rdy0, occ0, own0, cp0, st0, mc0, ill0} !== {1'b1, 41'd0} ||
            {rdy1, occ1, own1, cp1, st1, mc1, ill1} !== {1'b1, 49'd0} ||
            {rdy2, occ2, own2, cp2, st2, mc2, ill2} !== {1'b1, 15'd0})
            $display("FAIL reset_state: got d0 occ=%h st=%b mc=%0d rdy=%b d1 occ=%h d2 occ=%h, want all clear and ready",
                     occ0, st0, mc0, rdy0, occ1, occ2);
        else pass_cnt++;
        m_init(4, 4, 4);
        void'(m_drop(1));
        @(negedge clk); reset = 1'b1; v0 = 1'b1; c0 = 2'd1;
        @(negedge clk); v0 = 1'b0;
        tot_cnt++;
        if ({occ0, rdy0} !== {16'h0002, 1'b0})
            $display("FAIL first_drop_after_reset: got occ=%h rdy=%b want occ=0002 rdy=0", occ0, rdy0);
        else pass_cnt++;
        repeat (4) @(negedge clk);
        eo = m_occ(); ew = m_own();
        tot_cnt++;
        if ({occ0, own0, cp0, st0, mc0, ill0, rdy0} !== {eo[15:0], ew[15:0], m_player[0], m_status, 5'(m_count), 1'b0, 1'b1})
            $display("FAIL first_drop_resolve: got occ=%h own=%h cp=%b st=%b mc=%0d want occ=%h own=%h cp=%b st=%b mc=%0d",
                     occ0, own0, cp0, st0, mc0, eo[15:0], ew[15:0], m_player[0], m_status, m_count);
        else pass_cnt++;
    endtask

    task automatic test_vertical();
        int cols[6] = '{0, 1, 0, 1, 0, 1};
        int r;
        logic [63:0] eo, ew;
        newgame0();
        foreach (cols[i]) begin
            play0(cols[i], r);
            eo = m_occ(); ew = m_own();
            tot_cnt++;
            if ({occ0, own0, cp0, st0, mc0, ill0} !== {eo[15:0], ew[15:0], m_player[0], m_status, 5'(m_count), 1'b0})
                $display("FAIL vertical_mv%0d: got occ=%h own=%h cp=%b st=%b mc=%0d want occ=%h own=%h cp=%b st=%b mc=%0d",
                         i, occ0, own0, cp0, st0, mc0, eo[15:0], ew[15:0], m_player[0], m_status, m_count);
            else pass_cnt++;
        end
        r = m_drop(0);
        @(negedge clk); v0 = 1'b1; c0 = 2'd0;
        @(negedge clk); v0 = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            tot_cnt++;
            if ({rdy0, st0} !== 3'b000)
                $display("FAIL vertical_latency_e%0d: got rdy=%b st=%b want rdy=0 st=00", i, rdy0, st0);
            else pass_cnt++;
        end
        @(negedge clk);
        eo = m_occ(); ew = m_own();
        tot_cnt++;
        if ({occ0 & 16'h1111, st0, mc0, rdy0} !== {16'h1111, 2'b01, 5'd7, 1'b0} ||
            {occ0, own0, cp0} !== {eo[15:0], ew[15:0], m_player[0]})
            $display("FAIL vertical_win: got occ=%h own=%h st=%b mc=%0d rdy=%b want occ=%h own=%h st=01 mc=7 rdy=0",
                     occ0, own0, st0, mc0, rdy0, eo[15:0], ew[15:0]);
        else pass_cnt++;
        play0(2, r);
        tot_cnt++;
        if ({occ0, st0, mc0, ill0, rdy0} !== {eo[15:0], 2'b01, 5'd7, 1'b0, 1'b0})
            $display("FAIL over_ignore: got occ=%h st=%b mc=%0d ill=%b want occ=%h st=01 mc=7 ill=0",
                     occ0, st0, mc0, ill0, eo[15:0]);
        else pass_cnt++;
    endtask

    task automatic test_full_column();
        int r;
        logic [63:0] eo, ew;
        newgame0();
        for (int i = 0; i < 5; i++) begin
            play0(2, r);
            eo = m_occ(); ew = m_own();
            tot_cnt++;
            if ({occ0, own0, cp0, st0, mc0, ill0} !== {eo[15:0], ew[15:0], m_player[0], m_status, 5'(m_count), r == 0})
                $display("FAIL fullcol_drop%0d: got occ=%h own=%h cp=%b mc=%0d ill=%b want occ=%h own=%h cp=%b mc=%0d ill=%b",
                         i, occ0, own0, cp0, mc0, ill0, eo[15:0], ew[15:0], m_player[0], m_count, r == 0);
            else pass_cnt++;
        end
        tot_cnt++;
        if ({own0[14], own0[10], own0[6], own0[2], ill0, cp0, mc0} !== {4'b1010, 1'b1, 1'b0, 5'd4})
            $display("FAIL fullcol_reject: got own14/10/6/2=%b%b%b%b ill=%b cp=%b mc=%0d want 1010 ill=1 cp=0 mc=4",
                     own0[14], own0[10], own0[6], own0[2], ill0, cp0, mc0);
        else pass_cnt++;
        @(negedge clk);
        tot_cnt++;
        if ({ill0, rdy0} !== 2'b01)
            $display("FAIL fullcol_pulse_width: got ill=%b rdy=%b want ill=0 rdy=1", ill0, rdy0);
        else pass_cnt++;
    endtask

    task automatic test_out_of_range();
        int r;
        logic [63:0] eo, ew;
        @(negedge clk); ng1 = 1'b1; @(negedge clk); ng1 = 1'b0; m_init(4, 5, 4);
        play1(6, r);
        tot_cnt++;
        if ({ill1, occ1, mc1, cp1} !== {1'b1, 20'd0, 5'd0, 1'b0})
            $display("FAIL oor_reject: got ill=%b occ=%h mc=%0d cp=%b want ill=1 occ=0 mc=0 cp=0", ill1, occ1, mc1, cp1);
        else pass_cnt++;
        @(negedge clk);
        tot_cnt++;
        if (ill1 !== 1'b0) $display("FAIL oor_pulse_width: got ill=%b want 0", ill1);
        else pass_cnt++;
        play1(4, r);
        eo = m_occ(); ew = m_own();
        tot_cnt++;
        if ({occ1, own1, cp1, st1, mc1, ill1} !== {20'h00010, ew[19:0], m_player[0], m_status, 5'(m_count), 1'b0} ||
            occ1 !== eo[19:0])
            $display("FAIL oor_col4: got occ=%h own=%h cp=%b mc=%0d want occ=00010 own=%h cp=%b mc=%0d",
                     occ1, own1, cp1, mc1, ew[19:0], m_player[0], m_count);
        else pass_cnt++;
    endtask

    task automatic test_draw();
        int cols[4] = '{0, 1, 0, 1};
        int r;
        logic [63:0] eo, ew;
        @(negedge clk); ng2 = 1'b1; @(negedge clk); ng2 = 1'b0; m_init(2, 2, 4);
        foreach (cols[i]) begin
            play2(cols[i], r);
            eo = m_occ(); ew = m_own();
            tot_cnt++;
            if ({occ2, own2, cp2, st2, mc2, ill2} !== {eo[3:0], ew[3:0], m_player[0], m_status, 3'(m_count), 1'b0})
                $display("FAIL draw_mv%0d: got occ=%h own=%h cp=%b st=%b mc=%0d want occ=%h own=%h cp=%b st=%b mc=%0d",
                         i, occ2, own2, cp2, st2, mc2, eo[3:0], ew[3:0], m_player[0], m_status, m_count);
            else pass_cnt++;
        end
        tot_cnt++;
        if ({st2, rdy2} !== 3'b110) $display("FAIL draw_status: got st=%b rdy=%b want st=11 rdy=0", st2, rdy2);
        else pass_cnt++;
        @(negedge clk); ng2 = 1'b1; @(negedge clk); ng2 = 1'b0;
        tot_cnt++;
        if ({rdy2, occ2, own2, cp2, st2, mc2, ill2} !== {1'b1, 15'd0})
            $display("FAIL draw_newgame: got rdy=%b occ=%h own=%h cp=%b st=%b mc=%0d want rdy=1 rest 0",
                     rdy2, occ2, own2, cp2, st2, mc2);
        else pass_cnt++;
    endtask

    task automatic test_diagonal_ignore();
        int seq[11] = '{0, 1, 1, 2, 2, 3, 2, 3, 0, 3, 3};
        int r;
        logic [63:0] eo, ew;
        newgame0();
        foreach (seq[i]) begin
            if (i == 4) begin
                r = m_drop(seq[i]);
                @(negedge clk); v0 = 1'b1; c0 = 2'(seq[i]);
                @(negedge clk); c0 = 2'd0;
                @(negedge clk); v0 = 1'b0;
                eo = m_occ();
                tot_cnt++;
                if ({occ0, ill0, rdy0} !== {eo[15:0], 1'b0, 1'b0})
                    $display("FAIL check_ignore: got occ=%h ill=%b rdy=%b want occ=%h ill=0 rdy=0", occ0, ill0, rdy0, eo[15:0]);
                else pass_cnt++;
                repeat (3) @(negedge clk);
            end else begin
                play0(seq[i], r);
            end
            eo = m_occ(); ew = m_own();
            tot_cnt++;
            if ({occ0, own0, cp0, st0, mc0, ill0} !== {eo[15:0], ew[15:0], m_player[0], m_status, 5'(m_count), 1'b0})
                $display("FAIL diag_mv%0d: got occ=%h own=%h cp=%b st=%b mc=%0d want occ=%h own=%h cp=%b st=%b mc=%0d",
                         i, occ0, own0, cp0, st0, mc0, eo[15:0], ew[15:0], m_player[0], m_status, m_count);
            else pass_cnt++;
        end
        tot_cnt++;
        if ({occ0[15], occ0[10], occ0[5], occ0[0], own0[15], own0[10], own0[5], own0[0], st0} !== {4'hF, 4'h0, 2'b01})
            $display("FAIL diag_win: got occ=%h own=%h st=%b want diag cells p0 st=01", occ0, own0, st0);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        logic [63:0] eo, ew;
        newgame0();
        @(negedge clk); v0 = 1'b1; c0 = 2'd1;
        @(negedge clk); v0 = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        tot_cnt++;
        if ({rdy0, occ0, own0, cp0, st0, mc0, ill0} !== {1'b1, 41'd0})
            $display("FAIL async_reset: got rdy=%b occ=%h own=%h cp=%b st=%b mc=%0d want rdy=1 rest 0",
                     rdy0, occ0, own0, cp0, st0, mc0);
        else pass_cnt++;
        m_init(4, 4, 4);
        void'(m_drop(0));
        @(negedge clk); reset = 1'b1; v0 = 1'b1; c0 = 2'd0;
        @(negedge clk); v0 = 1'b0;
        repeat (4) @(negedge clk);
        eo = m_occ(); ew = m_own();
        tot_cnt++;
        if ({occ0, own0, cp0, st0, mc0, ill0, rdy0} !== {eo[15:0], ew[15:0], m_player[0], m_status, 5'(m_count), 1'b0, 1'b1} ||
            occ0 !== 16'h0001)
            $display("FAIL async_reset_release: got occ=%h own=%h cp=%b st=%b mc=%0d want occ=0001 cp=%b st=00 mc=1",
                     occ0, own0, cp0, st0, mc0, m_player[0]);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int r, col, extra;
        logic [63:0] eo, ew;
        for (int g = 0; g < 6; g++) begin
            newgame0();
            extra = 0;
            for (int mv = 0; mv < 40 && extra < 2; mv++) begin
                if (m_status != 2'b00) extra++;
                col = int'($urandom_range(3, 0));
                play0(col, r);
                eo = m_occ(); ew = m_own();
                tot_cnt++;
                if ({occ0, own0, cp0, st0, mc0, ill0} !== {eo[15:0], ew[15:0], m_player[0], m_status, 5'(m_count), r == 0})
                    $display("FAIL random_g%0d_mv%0d col%0d: got occ=%h own=%h cp=%b st=%b mc=%0d ill=%b want occ=%h own=%h cp=%b st=%b mc=%0d ill=%b",
                             g, mv, col, occ0, own0, cp0, st0, mc0, ill0,
                             eo[15:0], ew[15:0], m_player[0], m_status, m_count, r == 0);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_vertical();
        test_full_column();
        test_out_of_range();
        test_draw();
        test_diagonal_ignore();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", pass_cnt, tot_cnt);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/connect4_engine.md
CONNECT4_ENGINE -- requirements
Module: connect4_engine

Interface
REQ-001 Parameter ROWS, default 4: board rows; row 0 is the bottom row; legal range 1..8.
REQ-002 Parameter COLS, default 4: board columns; legal range 2..8.
REQ-003 Parameter WIN_LEN, default 4: run length that wins; legal range 2..8.
REQ-004 Localparams: N = ROWS*COLS; CW = clog2(COLS), minimum 1 bit; cell index = row*COLS + col.
REQ-005 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port drop_valid, input, 1 bit: one-cycle drop request, e.g. from the button-press detector.
REQ-008 Port drop_col, input, CW bits: requested column.
REQ-009 Port new_game, input, 1 bit: synchronous board clear.
REQ-010 Port drop_ready, output, 1 bit: engine accepts a drop this cycle.
REQ-011 Port occupied, output, N bits: 1 = cell filled.
REQ-012 Port owner, output, N bits: player of each filled cell; 0 where the cell is empty.
REQ-013 Port current_player, output, 1 bit: player to move.
REQ-014 Port game_status, output, 2 bits: 00 playing, 01 player0 won, 10 player1 won, 11 draw.
REQ-015 Port move_count, output, clog2(N+1) bits: number of accepted drops.
REQ-016 Port illegal_move, output, 1 bit: one-cycle pulse on a rejected drop.

Function
REQ-017 The state machine SHALL have three states:
- IDLE: drop_ready=1.
- CHECK: a 2-bit direction counter d steps 0..3; drop_ready=0.
- OVER: drop_ready=0.
REQ-018 Accepted drop: in IDLE with drop_valid=1, drop_col<COLS and the top cell of the column empty, the edge SHALL:
- set occupied and owner (=current_player) at the lowest empty row of that column;
- latch last_row and last_col;
- increment move_count;
- enter CHECK with d=0.
REQ-019 Rejected drop: in IDLE with drop_valid=1 and (drop_col>=COLS or column full), the block SHALL pulse illegal_move for exactly the next cycle and leave board, player and count unchanged.
REQ-020 Each CHECK cycle SHALL count cells owned by the player of last_row/last_col, along direction d only:
- d: 0 horizontal, 1 vertical, 2 diagonal up-right, 3 diagonal up-left.
- Counting SHALL include the placed cell and extend up to WIN_LEN-1 cells each way.
- Counting SHALL stop at the board edge, an empty cell or an opponent cell.
- A count of WIN_LEN or more SHALL set a sticky win flag.
REQ-021 Resolution happens on the d=3 edge:
- win flag set: game_status = 01 or 10 per the mover, enter OVER;
- else if move_count==N: game_status = 11, enter OVER;
- else: toggle current_player, enter IDLE.
REQ-022 Latency: the acceptance edge is E0; the result and drop_ready are updated on E4, so the next drop is accepted at E4 at the earliest.
REQ-023 drop_valid SHALL be ignored without an illegal_move pulse in CHECK and in OVER.
REQ-024 new_game=1 in any state SHALL have priority over drop_valid:
- clear occupied, owner, move_count and the win flag;
- current_player=0, game_status=00;
- enter IDLE on the next edge.
REQ-025 A win on the final cell SHALL report a win, not a draw.
REQ-026 owner bits for empty cells SHALL always be 0.

Reset
REQ-027 reset=0 SHALL immediately, regardless of clk, force:
- state=IDLE, d=0;
- occupied=0, owner=0, current_player=0;
- game_status=00, move_count=0, illegal_move=0;
- win flag cleared.
REQ-028 reset asserted during CHECK SHALL abandon the evaluation, with no partial status update after release.
REQ-029 The first drop SHALL be accepted on the first rising edge after reset is released.

Verification
REQ-030 Vertical win, 4x4 defaults: columns 0,1,0,1,0,1,0 -> game_status=01 four edges after the 7th drop, occupied bits 0,4,8,12 set, move_count=7, then state OVER.
REQ-031 Full column: five drops into column 2 -> the first four are accepted (owner bits 2,6,10,14 = 0,1,0,1); the fifth pulses illegal_move for one cycle, current_player is unchanged and move_count=4.
REQ-032 Out of range, COLS=5 (CW=3): drop_col=6 -> illegal_move pulse, board unchanged; drop_col=4 -> accepted at cell 4.
REQ-033 Draw, ROWS=2 COLS=2 WIN_LEN=4: drops in columns 0,1,0,1 -> game_status=11 after the 4th check, then new_game -> all outputs return to their reset values.
REQ-034 Diagonal and ignore: build a player0 up-right diagonal on cells 0,5,10,15 -> status=01; while in CHECK, a drop_valid pulse is ignored (no board change, no illegal_move pulse).
REQ-035 Async reset: assert reset on the second CHECK cycle -> all outputs reach their reset values before the next clk edge, and the first post-release drop lands in cell 0.
